// File: rtl/mole_game_ctrl_if.sv
// Game-control side-band bundle between the button/start front end,
// the mole game controller and the VGA display stage.
interface mole_game_ctrl_if;
   logic       start;
   logic [4:0] btn;
   logic [2:0] mole_position;
   logic       mole_visible;
   logic       guess_correct;
   logic       guess_wrong;
   logic       game_over;
   logic [3:0] digit_1;
   logic [3:0] digit_2;
   logic [2:0] lives_left;

   // Driver side: issues start/button pulses, observes game state.
   modport master (
      output start, btn,
      input  mole_position, mole_visible, guess_correct, guess_wrong,
             game_over, digit_1, digit_2, lives_left
   );

   // Controller side.
   modport slave (
      input  start, btn,
      output mole_position, mole_visible, guess_correct, guess_wrong,
             game_over, digit_1, digit_2, lives_left
   );
endinterface

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: picks pseudo-random mole holes, times the
// mole window and the gap between moles, scores hits in BCD (saturating at
// 99) and counts down lives. Every output is a flop.
module mole_game_ctrl #(
   parameter int          MOLE_TICKS = 50000000,
   parameter int          GAP_TICKS  = 10000000,
   parameter int          LIVES      = 3,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic           clk,
   input  logic           rst,
   mole_game_ctrl_if.slave gif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPAWN,
      S_ACTIVE,
      S_GAP,
      S_OVER
   } state_t;

   localparam int CNT_MAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
   localparam int CW      = $clog2(CNT_MAX + 1);

   // The no-mole interval is GAP + the single SPAWN cycle, so GAP itself
   // lasts GAP_TICKS-1 cycles and the total dark time is GAP_TICKS.
   // GAP_TICKS below 2 degenerates to one GAP cycle.
   localparam logic [CW-1:0] MOLE_LAST  = CW'(MOLE_TICKS - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_TICKS > 1) ? GAP_TICKS - 2 : 0);
   localparam logic [2:0]    LIVES_INIT = 3'(LIVES);

   state_t        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    pos_q, pos_d;
   logic          vis_q, vis_d;
   logic          corr_q, corr_d;
   logic          wrong_q, wrong_d;
   logic          over_q, over_d;
   logic [3:0]    tens_q, tens_d;
   logic [3:0]    ones_q, ones_d;
   logic [2:0]    lives_q, lives_d;

   logic          lfsr_fb;
   logic [2:0]    cand_raw;
   logic [2:0]    cand;
   logic [2:0]    new_pos;
   logic [4:0]    hit_mask;
   logic          miss;

   // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign lfsr_d  = {lfsr_fb, lfsr_q[15:1]};

   // Fold the 3-bit random value onto holes 0..4 and step past the current
   // hole so two consecutive moles never share a position.
   assign cand_raw = lfsr_q[2:0];
   assign cand     = (cand_raw >= 3'd5) ? cand_raw - 3'd5 : cand_raw;
   assign new_pos  = (cand != pos_q) ? cand :
                     (cand == 3'd4)  ? 3'd0 : cand + 3'd1;

   assign hit_mask = 5'd1 << pos_q;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      lives_d = lives_q;
      corr_d  = 1'b0;
      wrong_d = 1'b0;
      over_d  = 1'b0;
      miss    = 1'b0;

      case (state_q)
         S_IDLE, S_OVER: begin
            if (gif.start) begin
               lives_d = LIVES_INIT;
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               state_d = S_SPAWN;
            end
         end

         S_SPAWN: begin
            pos_d   = new_pos;
            cnt_d   = '0;
            state_d = S_ACTIVE;
         end

         S_ACTIVE: begin
            cnt_d = cnt_q + CW'(1);
            // A press on the final window cycle wins over the timeout.
            if (gif.btn != 5'd0) begin
               if (gif.btn == hit_mask) begin
                  corr_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = S_GAP;
                  if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                     if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                     end else begin
                        ones_d = ones_q + 4'd1;
                     end
                  end
               end else begin
                  miss = 1'b1;
               end
            end else if (cnt_q == MOLE_LAST) begin
               miss = 1'b1;
            end

            if (miss) begin
               wrong_d = 1'b1;
               lives_d = lives_q - 3'd1;
               cnt_d   = '0;
               if (lives_q == 3'd1) begin
                  over_d  = 1'b1;
                  state_d = S_OVER;
               end else begin
                  state_d = S_GAP;
               end
            end
         end

         S_GAP: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_SPAWN;
            end
         end

         default: state_d = S_IDLE;
      endcase

      vis_d = (state_d == S_ACTIVE);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Counter, LFSR, score, lives and output flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q  <= LFSR_SEED;
         cnt_q   <= '0;
         pos_q   <= 3'd0;
         vis_q   <= 1'b0;
         corr_q  <= 1'b0;
         wrong_q <= 1'b0;
         over_q  <= 1'b0;
         tens_q  <= 4'd0;
         ones_q  <= 4'd0;
         lives_q <= LIVES_INIT;
      end else begin
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         vis_q   <= vis_d;
         corr_q  <= corr_d;
         wrong_q <= wrong_d;
         over_q  <= over_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         lives_q <= lives_d;
      end
   end

   assign gif.mole_position = pos_q;
   assign gif.mole_visible  = vis_q;
   assign gif.guess_correct = corr_q;
   assign gif.guess_wrong   = wrong_q;
   assign gif.game_over     = over_q;
   assign gif.digit_1       = tens_q;
   assign gif.digit_2       = ones_q;
   assign gif.lives_left    = lives_q;

endmodule

// File: doc/mole_game_ctrl.md
Name: mole_game_ctrl

Overview:
- Game-control stage directly upstream of the VGA display stage of the whack-a-mole design.
- Takes debounced single-cycle button pulses and a start pulse, and picks pseudo-random mole positions.
- Times each mole window and keeps a BCD score (0-99) and a remaining-lives count.
- Drives `mole_position`, `guess_correct`, `guess_wrong`, `game_over`, `digit_1` and `digit_2` into the display stage.

Parameters:
- `MOLE_TICKS`, 50000000, clk cycles a mole stays up (ACTIVE window length).
- `GAP_TICKS`, 10000000, clk cycles with no mole between windows.
- `LIVES`, 3, lives loaded at game start; range 1..7.
- `LFSR_SEED`, 16'hACE1, non-zero LFSR reset value.

Ports:
- `clk`, input, 1, system clock (100 MHz).
- `rst`, input, 1, asynchronous active-low reset.
- `start`, input, 1, one-cycle start/restart pulse.
- `btn`, input, 5, one-cycle button pulses; bit i = hole i (0 top, 1 left, 2 center, 3 right, 4 bot).
- `mole_position`, output, 3, current or last mole hole, 0..4 only.
- `mole_visible`, output, 1, high while in ACTIVE.
- `guess_correct`, output, 1, one-cycle pulse on a hit.
- `guess_wrong`, output, 1, one-cycle pulse on a wrong press or timeout.
- `game_over`, output, 1, one-cycle pulse when lives reach 0.
- `digit_1`, output, 4, score tens (BCD).
- `digit_2`, output, 4, score ones (BCD).
- `lives_left`, output, 3, remaining lives.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - state = IDLE; all outputs 0, except `lives_left` = `LIVES`.
  - LFSR = `LFSR_SEED`; tick counter = 0.
- All outputs are registered.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11; advances every cycle except in reset.
  - Candidate = lfsr[2:0], minus 5 if ≥5.
  - If candidate == current `mole_position`, use (candidate+1) mod 5, so consecutive moles never repeat.
- States:
  - IDLE:
    - `start` → load lives = `LIVES`, score = 00, go to SPAWN.
    - `btn` ignored.
  - SPAWN (1 cycle):
    - latch new `mole_position`, clear counter, go to ACTIVE.
  - ACTIVE:
    - `mole_visible` = 1; counter increments each cycle.
    - If `btn` != 0 this cycle and `btn` == (1 << `mole_position`): hit.
      - next cycle `guess_correct` = 1, score += 1, go to GAP.
    - If `btn` != 0 and not an exact one-hot match (including multiple bits): wrong.
      - next cycle `guess_wrong` = 1, lives -= 1.
    - If `btn` == 0 and counter == `MOLE_TICKS`-1: timeout, handled identically to wrong.
    - A button press in the last window cycle takes priority over timeout.
    - After a wrong or timeout: if the new lives == 0, `game_over` = 1 in the same cycle as `guess_wrong`, go to OVER; otherwise go to GAP.
    - `start` ignored.
  - GAP:
    - `mole_visible` = 0; counts `GAP_TICKS` cycles, then goes to SPAWN.
    - `btn` ignored; `start` ignored.
  - OVER:
    - `mole_visible` = 0; score and `lives_left` (0) held.
    - `start` → same as from IDLE.
- Score:
  - BCD; ones wraps 9 → 0 with tens +1.
  - Saturates at 99: `guess_correct` still pulses, digits stay 9/9.
- Pulses: `guess_correct`, `guess_wrong` and `game_over` are high exactly one cycle each; `guess_correct` and `guess_wrong` are never high together.
- `mole_position` holds its last value outside ACTIVE and never exceeds 4.
- Reset mid-game: immediate return to reset values; no pulses emitted.

Test Plan:
- (Bench uses `MOLE_TICKS`=8, `GAP_TICKS`=4, `LIVES`=3.)
- Reset release, no start for 100 cycles → state IDLE, `mole_visible`=0, digits 0/0, `lives_left`=3, no pulses.
- `start`, then press the matching `btn` bit 3 cycles into ACTIVE → `guess_correct` 1 cycle later, `digit_2`=1, `mole_visible` low for 4 cycles, new `mole_position` ≠ previous.
- `start`, no presses → each window times out after 8 cycles with `guess_wrong`, `lives_left` 3 → 2 → 1 → 0. Third miss: `game_over` and `guess_wrong` in the same cycle, state OVER, digits held.
- In ACTIVE press `btn`=5'b00011 (mole at 0) → `guess_wrong`, `lives_left` -1. Matching press on the last window cycle → `guess_correct`, no timeout.
- Force 99 hits → digits 9/9; 100th hit still pulses `guess_correct`, digits remain 9/9. Then `start` in OVER → digits 0/0, `lives_left`=3.
- Assert `rst` low mid-ACTIVE → all outputs to reset values asynchronously. Release → IDLE; first mole after `start` matches the seed-derived sequence.
